// File: rtl/jk_count_ctrl.sv
// Modulo-MODULUS up/down counter with parallel load, JK excitation outputs for a shadow flop array,
// terminal count, registered wrap pulse and a sticky illegal-load flag. Asynchronous active-low clear.
module jk_count_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH compares correctly.
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_err;
  logic [WIDTH-1:0] w_next;
  logic             w_load_bad;
  logic             w_tc;

  always_comb begin
    w_load_bad = ({1'b0, d} >= LP_MOD);
    w_next     = r_q;
    if (load) begin
      w_next = w_load_bad ? '0 : d;
    end else if (en) begin
      if (up) begin
        w_next = (r_q == LP_MAX) ? '0 : r_q + WIDTH'(1);
      end else begin
        w_next = (r_q == '0) ? LP_MAX : r_q - WIDTH'(1);
      end
    end
  end

  assign w_tc = clr_n & en & ~load & (up ? (r_q == LP_MAX) : (r_q == '0));

  // Set/reset-only coding: bits that stay put get j=k=0, so toggle is never emitted.
  assign j_vec = {WIDTH{clr_n}} & ~r_q & w_next;
  assign k_vec = {WIDTH{clr_n}} & r_q & ~w_next;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_q    <= w_next;
      r_wrap <= w_tc;
      if (load && w_load_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign q    = r_q;
  assign tc   = w_tc;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Directed bench for jk_count_ctrl (WIDTH=4, MODULUS=10); outputs sampled on the falling clock edge.
module tb_jk_count_ctrl;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] j_vec;
  logic [3:0] k_vec;
  logic       tc;
  logic       wrap;
  logic       err;

  int errors = 0;
  int checks = 0;

  jk_count_ctrl #(.WIDTH(4), .MODULUS(10)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (en),
    .up    (up),
    .load  (load),
    .d     (d),
    .q     (q),
    .j_vec (j_vec),
    .k_vec (k_vec),
    .tc    (tc),
    .wrap  (wrap),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    clr_n = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd5;
    #1 clr_n = 1'b0;
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q_async got=%0d exp=0", q); end
    checks++; if (wrap !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got wrap=%b err=%b exp 0 0", wrap, err); end
    @(negedge clk);
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q_held got=%0d exp=0", q); end
    checks++; if (j_vec !== 4'd0 || k_vec !== 4'd0 || tc !== 1'b0) begin
      errors++; $display("FAIL reset_jk_tc got j=%b k=%b tc=%b exp 0000 0000 0", j_vec, k_vec, tc);
    end
  endtask

  task automatic test_up_count();
    logic [3:0] eq, en_q, ej, ek;
    clr_n = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      eq   = 4'(i % 10);
      en_q = 4'((i + 1) % 10);
      ej   = ~eq & en_q;
      ek   = eq & ~en_q;
      #1;
      checks++; if (q !== eq) begin errors++; $display("FAIL up_q step=%0d got=%0d exp=%0d", i, q, eq); end
      checks++; if (tc !== (eq == 4'd9)) begin errors++; $display("FAIL up_tc step=%0d got=%b exp=%b", i, tc, eq == 4'd9); end
      checks++; if (wrap !== (i == 10)) begin errors++; $display("FAIL up_wrap step=%0d got=%b exp=%b", i, wrap, i == 10); end
      checks++; if (j_vec !== ej || k_vec !== ek) begin
        errors++; $display("FAIL up_jk step=%0d got j=%b k=%b exp j=%b k=%b", i, j_vec, k_vec, ej, ek);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_down_count();
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1; up = 1'b0; en = 1'b1; load = 1'b0;
    #1;
    checks++; if (q !== 4'd0 || tc !== 1'b1) begin errors++; $display("FAIL down_start got q=%0d tc=%b exp 0 1", q, tc); end
    checks++; if (j_vec !== 4'b1001 || k_vec !== 4'b0000) begin
      errors++; $display("FAIL down_jk got j=%b k=%b exp 1001 0000", j_vec, k_vec);
    end
    @(negedge clk);
    checks++; if (q !== 4'd9 || wrap !== 1'b1) begin errors++; $display("FAIL down_wrap got q=%0d wrap=%b exp 9 1", q, wrap); end
    @(negedge clk);
    checks++; if (q !== 4'd8 || wrap !== 1'b0) begin errors++; $display("FAIL down_8 got q=%0d wrap=%b exp 8 0", q, wrap); end
    @(negedge clk);
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL down_7 got=%0d exp=7", q); end
  endtask

  task automatic test_jk_model();
    logic [3:0] mq;
    up = 1'b1;
    #1;
    checks++; if (j_vec !== 4'b1000 || k_vec !== 4'b0111) begin
      errors++; $display("FAIL jk_7to8 got j=%b k=%b exp 1000 0111", j_vec, k_vec);
    end
    mq = 4'd7;
    for (int b = 0; b < 4; b++) begin
      case ({j_vec[b], k_vec[b]})
        2'b10:   mq[b] = 1'b1;
        2'b01:   mq[b] = 1'b0;
        2'b11:   mq[b] = ~mq[b];
        default: mq[b] = mq[b];
      endcase
    end
    checks++; if (mq !== 4'd8) begin errors++; $display("FAIL jk_model got=%0d exp=8", mq); end
    @(negedge clk);
    checks++; if (q !== 4'd8) begin errors++; $display("FAIL jk_q got=%0d exp=8", q); end
  endtask

  task automatic test_load_same();
    load = 1'b1; d = 4'd8;
    #1;
    checks++; if (j_vec !== 4'd0 || k_vec !== 4'd0 || tc !== 1'b0) begin
      errors++; $display("FAIL load_same_jk got j=%b k=%b tc=%b exp 0000 0000 0", j_vec, k_vec, tc);
    end
    @(negedge clk);
    checks++; if (q !== 4'd8) begin errors++; $display("FAIL load_same_q got=%0d exp=8", q); end
  endtask

  task automatic test_hold();
    d = 4'd9;
    @(negedge clk);
    load = 1'b0; en = 1'b0; up = 1'b1;
    #1;
    checks++; if (tc !== 1'b0 || j_vec !== 4'd0 || k_vec !== 4'd0) begin
      errors++; $display("FAIL hold_outs got tc=%b j=%b k=%b exp 0 0000 0000", tc, j_vec, k_vec);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (q !== 4'd9 || wrap !== 1'b0) begin
        errors++; $display("FAIL hold_q step=%0d got q=%0d wrap=%b exp 9 0", i, q, wrap);
      end
    end
  endtask

  task automatic test_load_terminal();
    en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd3;
    #1;
    checks++; if (tc !== 1'b0 || j_vec !== 4'b0010 || k_vec !== 4'b1000) begin
      errors++; $display("FAIL ldterm_comb got tc=%b j=%b k=%b exp 0 0010 1000", tc, j_vec, k_vec);
    end
    @(negedge clk);
    checks++; if (q !== 4'd3 || wrap !== 1'b0) begin errors++; $display("FAIL ldterm_q got q=%0d wrap=%b exp 3 0", q, wrap); end
    d = 4'd9;
    @(negedge clk);
    checks++; if (q !== 4'd9 || wrap !== 1'b0) begin errors++; $display("FAIL ldterm_9 got q=%0d wrap=%b exp 9 0", q, wrap); end
    load = 1'b0;
  endtask

  task automatic test_mid_clear();
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL midclr_tc got=%b exp=1", tc); end
    clr_n = 1'b0;
    #1;
    checks++; if (q !== 4'd0 || wrap !== 1'b0 || j_vec !== 4'd0 || k_vec !== 4'd0 || tc !== 1'b0) begin
      errors++; $display("FAIL midclr_async got q=%0d wrap=%b j=%b k=%b tc=%b exp 0 0 0000 0000 0", q, wrap, j_vec, k_vec, tc);
    end
    #2 clr_n = 1'b1;
    @(negedge clk);
    checks++; if (q !== 4'd1 || wrap !== 1'b0) begin errors++; $display("FAIL midclr_resume got q=%0d wrap=%b exp 1 0", q, wrap); end
    @(negedge clk);
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL midclr_2 got=%0d exp=2", q); end
  endtask

  task automatic test_dir_change();
    up = 1'b0;
    @(negedge clk);
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL dir_down got=%0d exp=1", q); end
    up = 1'b1;
    @(negedge clk);
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL dir_up got=%0d exp=2", q); end
  endtask

  task automatic test_err();
    load = 1'b1; d = 4'd12;
    @(negedge clk);
    checks++; if (q !== 4'd0 || err !== 1'b1) begin errors++; $display("FAIL err_set got q=%0d err=%b exp 0 1", q, err); end
    d = 4'd5;
    @(negedge clk);
    checks++; if (q !== 4'd5 || err !== 1'b1) begin errors++; $display("FAIL err_load5 got q=%0d err=%b exp 5 1", q, err); end
    load = 1'b0; en = 1'b1; up = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (q !== 4'd7 || err !== 1'b1) begin errors++; $display("FAIL err_sticky got q=%0d err=%b exp 7 1", q, err); end
    #1 clr_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0 || q !== 4'd0) begin errors++; $display("FAIL err_clear got err=%b q=%0d exp 0 0", err, q); end
    clr_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_jk_model();
    test_load_same();
    test_hold();
    test_load_terminal();
    test_mid_clear();
    test_dir_change();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
